// File: rtl/param_register_file.sv
// Parametrised 2-write / 2-read register file with write-through bypass
// and a post-reset clear sequencer that zeroes every entry.
module param_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] wd2,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd2,
    output logic              init_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              clearing;
    logic              com1;
    logic              com2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {ADDR_W{1'b1}}) begin
                state_d = RUN;
            end
        end
    end

    // A write only commits (and so only bypasses) when it really lands.
    always_comb begin
        init_busy = (state_q == CLEAR);
        clearing  = (state_q == CLEAR) && !rst;
        com1      = (state_q == RUN) && !rst && we1 &&
                    !((ZERO_REG != 0) && (wa1 == '0));
        com2      = (state_q == RUN) && !rst && we2 &&
                    !((ZERO_REG != 0) && (wa2 == '0));
    end

    // Port 2 is written last so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (com1) begin
                mem_q[wa1] <= wd1;
            end
            if (com2) begin
                mem_q[wa2] <= wd2;
            end
        end
    end

    always_comb begin
        rd1 = mem_q[ra1];
        if (init_busy) begin
            rd1 = '0;
        end else if ((ZERO_REG != 0) && (ra1 == '0)) begin
            rd1 = '0;
        end else if (com2 && (wa2 == ra1)) begin
            rd1 = wd2;
        end else if (com1 && (wa1 == ra1)) begin
            rd1 = wd1;
        end
    end

    always_comb begin
        rd2 = mem_q[ra2];
        if (init_busy) begin
            rd2 = '0;
        end else if ((ZERO_REG != 0) && (ra2 == '0)) begin
            rd2 = '0;
        end else if (com2 && (wa2 == ra2)) begin
            rd2 = wd2;
        end else if (com1 && (wa1 == ra2)) begin
            rd2 = wd1;
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: default instance plus an 8-entry,
// no-zero-register instance, both checked against a behavioural model.
module tb_param_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we1 = 1'b0;
    logic        we2 = 1'b0;
    logic [4:0]  wa1 = '0;
    logic [4:0]  wa2 = '0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] wd1 = '0;
    logic [31:0] wd2 = '0;
    logic [31:0] rd1a;
    logic [31:0] rd2a;
    logic [31:0] rd1b;
    logic [31:0] rd2b;
    logic        busy_a;
    logic        busy_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    param_register_file u_a (
        .clk(clk), .rst(rst),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .we2(we2), .wa2(wa2), .wd2(wd2),
        .ra1(ra1), .rd1(rd1a),
        .ra2(ra2), .rd2(rd2a),
        .init_busy(busy_a)
    );

    param_register_file #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0)) u_b (
        .clk(clk), .rst(rst),
        .we1(we1), .wa1(wa1[2:0]), .wd1(wd1),
        .we2(we2), .wa2(wa2[2:0]), .wd2(wd2),
        .ra1(ra1[2:0]), .rd1(rd1b),
        .ra2(ra2[2:0]), .rd2(rd2b),
        .init_busy(busy_b)
    );

    // Model: clr = edges of clear left; storage is all-zero once it ends.
    int          clr [2];
    logic [31:0] mem [2][32];
    bit          known = 0;

    function automatic int dep(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    function automatic bit zr(input int d);
        return d == 0;
    endfunction

    function automatic logic [31:0] exp_rd(input int d, input logic [4:0] a);
        int m  = dep(d) - 1;
        int ai = int'(a) & m;
        int w1 = int'(wa1) & m;
        int w2 = int'(wa2) & m;
        if (clr[d] != 0) return 32'h0;
        if (zr(d) && ai == 0) return 32'h0;
        if (!rst && we2 && w2 == ai && !(zr(d) && w2 == 0)) return wd2;
        if (!rst && we1 && w1 == ai && !(zr(d) && w1 == 0)) return wd1;
        return mem[d][ai];
    endfunction

    task automatic model_edge(input int d);
        int m  = dep(d) - 1;
        int w1 = int'(wa1) & m;
        int w2 = int'(wa2) & m;
        if (rst) begin
            clr[d] = dep(d);
        end else if (clr[d] > 0) begin
            clr[d]--;
            if (clr[d] == 0)
                for (int i = 0; i < 32; i++) mem[d][i] = 32'h0;
        end else begin
            if (we1 && !(zr(d) && w1 == 0)) mem[d][w1] = wd1;
            if (we2 && !(zr(d) && w2 == 0)) mem[d][w2] = wd2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (known) begin
            chk("busy_a", {31'h0, busy_a}, {31'h0, clr[0] != 0});
            chk("busy_b", {31'h0, busy_b}, {31'h0, clr[1] != 0});
            chk("rd1a", rd1a, exp_rd(0, ra1));
            chk("rd2a", rd2a, exp_rd(0, ra2));
            chk("rd1b", rd1b, exp_rd(1, ra1));
            chk("rd2b", rd2b, exp_rd(1, ra2));
        end
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        if (rst) known = 1;
        #1;
    endtask

    task automatic measure(input string tag);
        int na = -1;
        int nb = -1;
        for (int i = 0; i < 40 && na < 0; i++) begin
            cyc();
            if (!busy_a && na < 0) na = i + 1;
            if (!busy_b && nb < 0) nb = i + 1;
        end
        chk({tag, "_a"}, na, 32);
        chk({tag, "_b"}, nb, 8);
    endtask

    initial begin
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        we1 = 1'b1; wa1 = 5'd31; wd1 = 32'hA5A5A5A5; ra1 = 5'd31;
        measure("clr_len");
        we1 = 1'b0;
        #1;
        chk("clr_wr31", rd1a, 32'h0);

        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            chk("sweep", rd1a | rd2a, 32'h0);
            cyc();
        end

        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hDEADBEEF; ra1 = 5'd5;
        #1;
        chk("byp1", rd1a, 32'hDEADBEEF);
        cyc();
        we1 = 1'b0;
        #1;
        chk("wr1", rd1a, 32'hDEADBEEF);
        cyc();

        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h11111111;
        we2 = 1'b1; wa2 = 5'd7; wd2 = 32'h22222222; ra2 = 5'd7;
        #1;
        chk("col_byp", rd2a, 32'h22222222);
        cyc();
        we1 = 1'b0; we2 = 1'b0;
        #1;
        chk("col_a", rd2a, 32'h22222222);
        chk("col_b", rd2b, 32'h22222222);
        cyc();

        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
        we2 = 1'b1; wa2 = 5'd0; wd2 = 32'hFFFFFFFF; ra1 = 5'd0;
        #1;
        chk("zr_byp", rd1a, 32'h0);
        chk("nz_byp", rd1b, 32'hFFFFFFFF);
        cyc();
        we1 = 1'b0; we2 = 1'b0;
        #1;
        chk("zr_wr", rd1a, 32'h0);
        chk("nz_wr", rd1b, 32'hFFFFFFFF);
        cyc();

        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h12345678; ra1 = 5'd9;
        rst = 1'b1;
        #1;
        chk("rst_nobyp", rd1a, 32'h0);
        cyc();
        we1 = 1'b0;
        #1;
        chk("rst_busy", {31'h0, busy_a}, 32'h1);
        chk("rst_rd", rd2a, 32'h0);
        rst = 1'b0;
        repeat (10) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        measure("mid_rst");

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(63) == 0);
            we1 = $urandom_range(1);
            we2 = $urandom_range(1);
            wa1 = 5'($urandom);
            wa2 = ($urandom_range(3) == 0) ? wa1 : 5'($urandom);
            ra1 = ($urandom_range(2) == 0) ? wa1 : 5'($urandom);
            ra2 = ($urandom_range(2) == 0) ? wa2 : 5'($urandom);
            wd1 = $urandom;
            wd2 = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised, two-write/two-read register file for the single-cycle datapath, and the successor to the fixed 32x32 register file. Data width and depth are configurable, and entry 0 can optionally be hardwired to zero. It adds a second write port with defined collision priority, write-through bypass to both read ports, and a hardware clear sequencer. After reset the sequencer zeroes every entry, so simulation and silicon never read X.

## Interface

Parameters:
- DATA_W, default 32: width of each entry and of all data ports.
- ADDR_W, default 5: address width. DEPTH = 2^ADDR_W entries.
- ZERO_REG, default 1: when 1, entry 0 always reads 0 and writes to it are discarded. When 0, entry 0 is an ordinary entry.

Ports:
- clk  in  1  Single clock. All state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset. Sampled on the rising edge of clk.
- we1  in  1  Write enable, port 1.
- wa1  in  ADDR_W  Write address, port 1.
- wd1  in  DATA_W  Write data, port 1.
- we2  in  1  Write enable, port 2.
- wa2  in  ADDR_W  Write address, port 2.
- wd2  in  DATA_W  Write data, port 2.
- ra1  in  ADDR_W  Read address, port 1.
- rd1  out  DATA_W  Read data, port 1. Combinational.
- ra2  in  ADDR_W  Read address, port 2.
- rd2  out  DATA_W  Read data, port 2. Combinational.
- init_busy  out  1  High while the clear sequence is running. Combinational from state.

## Operation

- Two states: CLEAR and RUN. A clear counter `cnt` is ADDR_W bits wide.
- On an edge with rst=1:
  - state <= CLEAR, cnt <= 0.
  - No entry is written. The contents of the storage array are unchanged by reset itself.
- On an edge in CLEAR with rst=0:
  - mem[cnt] <= 0 and cnt <= cnt+1.
  - If cnt == DEPTH-1, state <= RUN and cnt wraps to 0.
  - we1 and we2 are ignored for the whole of CLEAR.
- In RUN, on an edge with rst=0:
  - Port 1 commits if we1=1. Port 2 commits if we2=1.
  - If both ports write the same address, port 2 wins and the port 1 data is lost.
  - If ZERO_REG=1, any write addressed to 0 is discarded.
- Reads:
  - In CLEAR, rdN = 0 for every address.
  - In RUN, if ZERO_REG=1 and raN==0, rdN = 0.
  - Otherwise, if we2=1 and wa2==raN, rdN = wd2 (bypass, port 2 has priority).
  - Otherwise, if we1=1 and wa1==raN, rdN = wd1 (bypass).
  - Otherwise rdN = mem[raN].
  - The bypass applies only to a write that will actually commit. It never applies in CLEAR, and never for address 0 when ZERO_REG=1.
- init_busy = (state == CLEAR).
- No arithmetic is performed on data; data passes through unmodified at DATA_W bits. cnt arithmetic is modulo DEPTH.

## Timing

- Read latency is 0 cycles: combinational from the address inputs, the write-port inputs (bypass) and state.
- Write latency is 1 edge. Data is visible from storage after the edge, and visible via bypass in the same cycle.
- Clear duration is exactly DEPTH rising edges with rst=0 after the last edge with rst=1. That is 32 edges at the default parameters.
  - init_busy falls right after the DEPTH-th such edge.
  - A write presented in the cycle after init_busy falls commits normally.
- init_busy and rd1/rd2 after reset: on the edge where rst is sampled high, init_busy becomes 1 and rd1/rd2 become 0. Both stay there until RUN is entered.
- Reset asserted mid-clear: on the next edge, cnt <= 0 and state stays CLEAR. The full DEPTH-edge sweep restarts once rst drops.
- Reset asserted in RUN: any write in that cycle is discarded and CLEAR is entered.
- Before the first rst, state is undefined. The bench must apply rst before checking anything.

## Test plan

1. Clear sequence (DATA_W=32, ADDR_W=5): assert rst for 2 edges, then release. init_busy stays 1 for exactly 32 edges, then falls. Every address then reads 32'h0.
2. Write and bypass: in RUN, we1=1, wa1=5, wd1=32'hDEADBEEF, ra1=5. In the same cycle rd1=32'hDEADBEEF. After the edge, with we1=0, rd1 still reads 32'hDEADBEEF.
3. Collision: we1=1/wa1=7/wd1=32'h11111111 and we2=1/wa2=7/wd2=32'h22222222 together. rd2 (ra2=7) shows 32'h22222222 in the same cycle and afterwards.
4. Zero register: with ZERO_REG=1, write 32'hFFFFFFFF to address 0 on both ports. rd1 with ra1=0 reads 0 in the same cycle and afterwards. Rerun with ZERO_REG=0: rd1 reads 32'hFFFFFFFF.
5. Writes in CLEAR are dropped: during CLEAR, hold we1=1/wa1=31/wd1=32'hA5A5A5A5. rd1 reads 0 throughout. After init_busy falls, address 31 reads 0.
6. Reset mid-clear: release rst, wait 10 edges, pulse rst for 1 edge, release. init_busy falls exactly 32 edges after the second release. Repeat with ADDR_W=3 and expect 8 edges.
